// File: rtl/hwag_pkg.sv
// Shared wheel geometry and FSM encoding for the hwag trigger-wheel
// generator and the hwag angle decoder, so both ends agree on the wheel.
package hwag_pkg;

    localparam int TEETH_TOTAL   = 60;
    localparam int TEETH_MISSING = 2;
    localparam int CAM_START     = 10;
    localparam int CAM_LEN       = 4;
    localparam int MIN_PERIOD    = 2;
    localparam int SLOT_W        = 6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/hwag_sim_slot_timer.sv
// Slot timer: tick counter, period shadow (clamped to MIN_PERIOD) and the
// slot-end strobe.  The shadow only changes at a slot boundary, so a period
// written mid-slot never disturbs the slot in progress.
module hwag_sim_slot_timer
    import hwag_pkg::*;
#(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    output logic [PERIOD_W-1:0] tick,
    output logic [PERIOD_W-1:0] shadow,
    output logic                slot_end
);

    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
        return (p < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : p;
    endfunction

    // Last tick of the current slot.
    assign slot_end = (tick == (shadow - PERIOD_W'(1)));

    // Tick counter and period shadow; both cleared whenever the wheel is not running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick   <= '0;
            shadow <= '0;
        end else if (load) begin
            tick   <= '0;
            shadow <= clamp_period(period);
        end else if (run) begin
            if (slot_end) begin
                tick   <= '0;
                shadow <= clamp_period(period);
            end else begin
                tick   <= tick + PERIOD_W'(1);
            end
        end else begin
            tick   <= '0;
            shadow <= '0;
        end
    end

endmodule

// File: rtl/hwag_wheel_sim.sv
// 60-2 crank / cam trigger-wheel generator.  The FSM, slot index, revolution
// parity and output decode live here; slot timing is in hwag_sim_slot_timer.
// All outputs are registered and are computed from the state that the same
// edge establishes, so no combinational path exists from ena/period.
module hwag_wheel_sim
    import hwag_pkg::*;
#(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [PERIOD_W-1:0] period,
    output logic                cap,
    output logic                cam,
    output logic [5:0]          tooth_idx,
    output logic                rev_pulse,
    output logic                busy
);

    localparam logic [SLOT_W-1:0] LAST_SLOT     = SLOT_W'(TEETH_TOTAL - 1);
    localparam logic [SLOT_W-1:0] PRESENT_SLOTS = SLOT_W'(TEETH_TOTAL - TEETH_MISSING);

    state_t              state;
    state_t              state_next;
    logic                load;
    logic                run;
    logic [PERIOD_W-1:0] tick;
    logic [PERIOD_W-1:0] shadow;
    logic                slot_end;
    logic                parity;
    logic                slot_wrap;
    logic [SLOT_W-1:0]   slot_next;
    logic                parity_next;
    logic [PERIOD_W-1:0] tick_inc;

    // Cam window: even revolutions only, a fixed run of slots.
    function automatic logic cam_window(input logic [SLOT_W-1:0] slot, input logic par);
        return (!par) && (slot >= SLOT_W'(CAM_START)) && (slot < SLOT_W'(CAM_START + CAM_LEN));
    endfunction

    assign load        = (state == IDLE) && ena;
    assign run         = (state == RUN) && ena;
    assign slot_wrap   = (tooth_idx == LAST_SLOT);
    assign slot_next   = slot_wrap ? '0 : (tooth_idx + SLOT_W'(1));
    assign parity_next = parity ^ slot_wrap;
    assign tick_inc    = tick + PERIOD_W'(1);

    hwag_sim_slot_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .run      (run),
        .period   (period),
        .tick     (tick),
        .shadow   (shadow),
        .slot_end (slot_end)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: ena is a level run request, stop always wins.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ena) begin
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (!ena) begin
                    state_next = IDLE;
                end else begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Slot/parity counters and registered output decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tooth_idx <= '0;
            parity    <= 1'b0;
            cap       <= 1'b0;
            cam       <= 1'b0;
            rev_pulse <= 1'b0;
            busy      <= 1'b0;
        end else if (load) begin
            // Slot 0 starts: the shadow is at least MIN_PERIOD so tick 0 is high.
            tooth_idx <= '0;
            parity    <= 1'b0;
            cap       <= 1'b1;
            cam       <= cam_window('0, 1'b0);
            rev_pulse <= 1'b1;
            busy      <= 1'b1;
        end else if (run) begin
            busy <= 1'b1;
            if (slot_end) begin
                tooth_idx <= slot_next;
                parity    <= parity_next;
                cap       <= (slot_next < PRESENT_SLOTS);
                cam       <= cam_window(slot_next, parity_next);
                rev_pulse <= slot_wrap;
            end else begin
                cap       <= (tooth_idx < PRESENT_SLOTS) && (tick_inc < (shadow >> 1));
                rev_pulse <= 1'b0;
            end
        end else begin
            tooth_idx <= '0;
            parity    <= 1'b0;
            cap       <= 1'b0;
            cam       <= 1'b0;
            rev_pulse <= 1'b0;
            busy      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hwag_wheel_sim.sv
// Directed bench for hwag_wheel_sim: a table of {inputs, cycles, expected
// outputs} records plus hand-written sequences for stop, reset, period change
// and whole-revolution geometry/cam measurements.
module tb_hwag_wheel_sim;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [23:0] period;
    logic        cap;
    logic        cam;
    logic [5:0]  tooth_idx;
    logic        rev_pulse;
    logic        busy;

    int tests;
    int fails;

    // exp packs {cap, cam, tooth_idx[5:0], rev_pulse, busy}
    typedef struct {
        logic        ena;
        logic [23:0] period;
        int          n;
        logic [9:0]  exp;
    } vec_t;

    vec_t vecs[21];

    hwag_wheel_sim #(.PERIOD_W(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .period    (period),
        .cap       (cap),
        .cam       (cam),
        .tooth_idx (tooth_idx),
        .rev_pulse (rev_pulse),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic e, input int p, input int n,
                                input logic c, input logic m, input int idx,
                                input logic r, input logic b);
        vec_t v;
        v.ena    = e;
        v.period = 24'(p);
        v.n      = n;
        v.exp    = {c, m, 6'(idx), r, b};
        return v;
    endfunction

    function automatic logic [9:0] outs();
        return {cap, cam, tooth_idx, rev_pulse, busy};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = outs();
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got cap=%b cam=%b idx=%0d rev=%b busy=%b, want cap=%b cam=%b idx=%0d rev=%b busy=%b",
                     name, act[9], act[8], act[7:2], act[1], act[0],
                     exp[9], exp[8], exp[7:2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    localparam logic [9:0] ZERO = 10'b0;

    initial begin
        int rises, highs, revs, rev_j, s8, s24, sother, last_fall;
        int cam_highs, cam_rises, cam_first;
        logic prev, prev_cam;

        tests  = 0;
        fails  = 0;
        rst    = 1'b1;
        ena    = 1'b0;
        period = 24'd0;

        // Period 4 wheel: slot = j/4, tick = j%4, cap high on ticks 0..1.
        vecs[0]  = mk(1'b1, 4, 1,   1'b1, 1'b0, 0,  1'b1, 1'b1);
        vecs[1]  = mk(1'b1, 4, 1,   1'b1, 1'b0, 0,  1'b0, 1'b1);
        vecs[2]  = mk(1'b1, 4, 1,   1'b0, 1'b0, 0,  1'b0, 1'b1);
        vecs[3]  = mk(1'b1, 4, 2,   1'b1, 1'b0, 1,  1'b0, 1'b1);
        vecs[4]  = mk(1'b1, 4, 36,  1'b1, 1'b1, 10, 1'b0, 1'b1);
        vecs[5]  = mk(1'b1, 4, 16,  1'b1, 1'b0, 14, 1'b0, 1'b1);
        vecs[6]  = mk(1'b1, 4, 176, 1'b0, 1'b0, 58, 1'b0, 1'b1);
        vecs[7]  = mk(1'b1, 4, 7,   1'b0, 1'b0, 59, 1'b0, 1'b1);
        vecs[8]  = mk(1'b1, 4, 1,   1'b1, 1'b0, 0,  1'b1, 1'b1);
        vecs[9]  = mk(1'b1, 4, 40,  1'b1, 1'b0, 10, 1'b0, 1'b1);
        vecs[10] = mk(1'b1, 4, 200, 1'b1, 1'b0, 0,  1'b1, 1'b1);
        vecs[11] = mk(1'b1, 4, 40,  1'b1, 1'b1, 10, 1'b0, 1'b1);
        // period 0 written at tick 0 of slot 10: slot 10 stays 4, then 2-tick slots
        vecs[12] = mk(1'b1, 0, 4,   1'b1, 1'b1, 11, 1'b0, 1'b1);
        vecs[13] = mk(1'b1, 0, 1,   1'b0, 1'b1, 11, 1'b0, 1'b1);
        vecs[14] = mk(1'b1, 0, 1,   1'b1, 1'b1, 12, 1'b0, 1'b1);
        vecs[15] = mk(1'b1, 0, 2,   1'b1, 1'b1, 13, 1'b0, 1'b1);
        vecs[16] = mk(1'b1, 0, 2,   1'b1, 1'b0, 14, 1'b0, 1'b1);
        vecs[17] = mk(1'b0, 0, 1,   1'b0, 1'b0, 0,  1'b0, 1'b0);
        vecs[18] = mk(1'b0, 0, 3,   1'b0, 1'b0, 0,  1'b0, 1'b0);
        vecs[19] = mk(1'b1, 1, 1,   1'b1, 1'b0, 0,  1'b1, 1'b1);
        vecs[20] = mk(1'b0, 1, 1,   1'b0, 1'b0, 0,  1'b0, 1'b0);

        // Reset state
        step(3);
        check_outs("reset_state", ZERO);
        rst = 1'b0;
        step(2);
        check_outs("idle_no_ena", ZERO);

        // Table-driven vectors
        for (int i = 0; i < 21; i++) begin
            ena    = vecs[i].ena;
            period = vecs[i].period;
            step(vecs[i].n);
            check_outs($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Period change mid-slot: 300 -> 500 at tick 50 of slot 0
        period = 24'd300;
        ena    = 1'b1;
        step(1);
        check_outs("pchg_start", {1'b1, 1'b0, 6'd0, 1'b1, 1'b1});
        step(50);
        period = 24'd500;
        step(99);
        check_outs("pchg_tick149", {1'b1, 1'b0, 6'd0, 1'b0, 1'b1});
        step(1);
        check_outs("pchg_tick150", {1'b0, 1'b0, 6'd0, 1'b0, 1'b1});
        step(149);
        check_outs("pchg_tick299", {1'b0, 1'b0, 6'd0, 1'b0, 1'b1});
        step(1);
        check_outs("pchg_slot1", {1'b1, 1'b0, 6'd1, 1'b0, 1'b1});
        step(249);
        check_outs("pchg_s1_tick249", {1'b1, 1'b0, 6'd1, 1'b0, 1'b1});
        step(1);
        check_outs("pchg_s1_tick250", {1'b0, 1'b0, 6'd1, 1'b0, 1'b1});
        step(249);
        check_outs("pchg_s1_tick499", {1'b0, 1'b0, 6'd1, 1'b0, 1'b1});
        step(1);
        check_outs("pchg_slot2", {1'b1, 1'b0, 6'd2, 1'b0, 1'b1});
        ena = 1'b0;
        step(1);
        check_outs("pchg_stop", ZERO);

        // Stop mid-tooth: slot 5, tick 9 of a 20-tick slot
        period = 24'd20;
        ena    = 1'b1;
        step(1);
        step(109);
        check_outs("midtooth_before", {1'b1, 1'b0, 6'd5, 1'b0, 1'b1});
        ena = 1'b0;
        step(1);
        check_outs("midtooth_stop", ZERO);

        // Stop exactly at a revolution boundary: no new slot, no rev_pulse
        period = 24'd4;
        ena    = 1'b1;
        step(1);
        step(239);
        check_outs("bnd_before", {1'b0, 1'b0, 6'd59, 1'b0, 1'b1});
        ena = 1'b0;
        step(1);
        check_outs("bnd_stop", ZERO);
        step(1);
        check_outs("bnd_stay_idle", ZERO);

        // Asynchronous reset mid-RUN, then restart at slot 0
        period = 24'd1000;
        ena    = 1'b1;
        step(1);
        step(1500);
        check_outs("arst_before", {1'b0, 1'b0, 6'd1, 1'b0, 1'b1});
        #2 rst = 1'b1;
        #1;
        check_outs("arst_async", ZERO);
        step(1);
        check_outs("arst_held", ZERO);
        rst = 1'b0;
        step(1);
        check_outs("arst_restart", {1'b1, 1'b0, 6'd0, 1'b1, 1'b1});
        step(1);
        check_outs("arst_restart2", {1'b1, 1'b0, 6'd0, 1'b0, 1'b1});
        ena = 1'b0;
        step(1);

        // Geometry over one revolution at period 8
        period    = 24'd8;
        ena       = 1'b1;
        rises     = 0;
        highs     = 0;
        revs      = 0;
        rev_j     = -1;
        s8        = 0;
        s24       = 0;
        sother    = 0;
        last_fall = -1;
        prev      = 1'b0;
        step(1);
        for (int j = 0; j <= 484; j++) begin
            if (j > 0) step(1);
            if (j < 480) begin
                if (cap && !prev) rises++;
                if (cap) highs++;
            end
            if (j >= 1 && rev_pulse) begin
                revs++;
                rev_j = j;
            end
            if (prev && !cap) begin
                if (last_fall >= 0) begin
                    if (j - last_fall == 8) s8++;
                    else if (j - last_fall == 24) s24++;
                    else sother++;
                end
                last_fall = j;
            end
            prev = cap;
        end
        check_int("geo_rises", rises, 58);
        check_int("geo_high_cycles", highs, 232);
        check_int("geo_rev_count", revs, 1);
        check_int("geo_rev_period", rev_j, 480);
        check_int("geo_spacing_p", s8, 57);
        check_int("geo_spacing_3p", s24, 1);
        check_int("geo_spacing_other", sother, 0);
        ena = 1'b0;
        step(1);

        // Cam phasing over four revolutions at period 4
        period    = 24'd4;
        ena       = 1'b1;
        cam_highs = 0;
        cam_rises = 0;
        cam_first = -1;
        prev_cam  = 1'b0;
        step(1);
        for (int j = 0; j < 960; j++) begin
            if (j > 0) step(1);
            if (cam) cam_highs++;
            if (cam && !prev_cam) begin
                cam_rises++;
                if (cam_first < 0) cam_first = j;
            end
            prev_cam = cam;
        end
        check_int("cam_high_cycles", cam_highs, 32);
        check_int("cam_rises", cam_rises, 2);
        check_int("cam_first_rise", cam_first, 40);
        ena = 1'b0;
        step(1);
        check_outs("final_idle", ZERO);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hwag_wheel_sim.md
Name: hwag_wheel_sim

Overview:
- Crank/cam trigger-wheel generator: synthesises the 60-2 crank tooth signal (cap) and a once-per-cycle cam signal (cam) from a programmable tooth period.
- Transmitter counterpart of the hwag angle decoder.
- Drives the hwag cap/cam inputs in loopback benches and on the bench-top FPGA ECU stimulator.

Parameters:
- TEETH_TOTAL, 60, tooth slots per revolution, including missing ones.
- TEETH_MISSING, 2, missing slots at the end of each revolution.
- PERIOD_W, 24, width of the tooth-period input, in clk ticks.
- CAM_START, 10, first slot of the cam high window, even revolution only.
- CAM_LEN, 4, cam window length in slots.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ena  in  1  run request; level-sensitive
- period  in  PERIOD_W  tooth slot length in clk ticks; sampled at slot boundaries
- cap  out  1  crank tooth signal
- cam  out  1  cam phase signal
- tooth_idx  out  6  current slot index, 0..TEETH_TOTAL-1
- rev_pulse  out  1  one-cycle pulse at the start of slot 0
- busy  out  1  high while in RUN

Behaviour:
- Reset (async, rst=1): state IDLE. cap, cam, rev_pulse and busy = 0. tooth_idx = 0. Tick counter = 0. Period shadow = 0. Revolution parity = 0.
- FSM states: IDLE, RUN.
- IDLE -> RUN: on the first clk edge with ena=1.
  - That edge loads the period shadow, clears the tick counter, sets slot = 0 and parity = 0.
  - The same edge drives cap=1 and pulses rev_pulse. Latency from ena sampled high to cap high is 1 clk.
- RUN -> IDLE: on the first clk edge with ena=0.
  - Stop takes effect immediately, even mid-tooth. All outputs return to reset values on that edge.
- Period shadow: loaded only at slot boundaries (tick counter wrap and IDLE->RUN).
  - Values below 2 are clamped to 2.
  - A change of period mid-slot does not affect the current slot.
- Tick counter: counts 0..shadow-1 and wraps. The wrap ends the slot and advances the slot index.
  - Slot index wraps TEETH_TOTAL-1 -> 0 and toggles parity on that wrap.
- cap waveform in a present slot (index < TEETH_TOTAL-TEETH_MISSING):
  - cap=1 while tick < shadow>>1, then cap=0.
  - The falling edge therefore sits at tick = shadow>>1.
- cap in missing slots: held 0.
  - Consecutive falling edges are spaced shadow ticks, except across the gap, where the spacing is (TEETH_MISSING+1)*shadow.
  - With a constant period this gives 57 intervals of P and 1 of 3P per revolution.
- cam: 1 while parity=0 and CAM_START <= slot < CAM_START+CAM_LEN; 0 otherwise. Updates at slot boundaries only, so it is glitch-free. cam has 1 rising edge per 2 revolutions.
- rev_pulse: 1 on the clk cycle in which slot 0 begins, on every revolution including the first.
- Registering: all outputs are registered. No combinational path from ena or period to any output.
- Simultaneous events: ena falling at a slot boundary gives priority to stop; no new slot is started and no rev_pulse is emitted.

Decomposition:
- hwag_pkg holds:
  - TEETH_TOTAL and TEETH_MISSING defaults
  - cam window constants
  - MIN_PERIOD = 2
  - the FSM state enum (IDLE, RUN)
- hwag_decoder shares hwag_pkg so that both ends agree on the wheel geometry.
- One sub-module, hwag_sim_slot_timer: tick counter, period shadow with clamp, and slot-end strobe. The top level holds the FSM, slot/parity counters and output decode.

Test Plan:
- Reset/idle:
  - Stimulus: rst pulse mid-RUN, period=1000.
  - Response: all outputs 0 asynchronously; tooth_idx=0; RUN resumes at slot 0 one clk after rst is released with ena=1.
- Geometry:
  - Stimulus: ena=1, period=256, one full revolution.
  - Response: 58 rising edges. cap high time 128. Fall-to-fall spacing 256 (x57) and 768 (x1). rev_pulse period 15360 clk.
- Cam phasing:
  - Stimulus: period=100, 4 revolutions.
  - Response: cam high exactly 400 clk starting at the slot-10 boundary, in revolutions 0 and 2 only.
- Period change and clamp:
  - Stimulus: period 300 -> 500 written at tick 50 of a slot. Later period=0.
  - Response: the current slot stays 300; the next slot is 500. period=0 gives 2-tick slots with cap high 1 tick.
- Stop mid-tooth:
  - Stimulus: ena deasserted at tick 10 of slot 5.
  - Response: on the next edge cap=0, busy=0, tooth_idx=0; no rev_pulse.
- Loopback:
  - Stimulus: cap/cam drive hwag, period=1024.
  - Response: hwag_start asserts within 2 revolutions. ngap_point goes low once per revolution, aligned to the gap. hwag_start never drops over 10 revolutions.
